// File: rtl/decode.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// decode -- instruction decode stage of the byter 8-bit core.
//
// Collects the byte stream coming from fetch into complete instructions
// (opcode plus 0..2 operand bytes) and presents each one to execute through a
// valid/ready handshake. A partially received instruction is held internally
// until its last byte arrives.
//
// Ports:
//   clk          in   1  single clock, rising edge
//   reset        in   1  synchronous, active-high
//   enabled      in   1  stage enable, gates byte acceptance only
//   in_valid     in   1  in_data holds a fetched byte
//   in_data      in   8  byte from fetch
//   in_ready     out  1  byte accepted this cycle when in_valid is also high
//   out_valid    out  1  complete instruction presented
//   out_ready    in   1  execute consumes the presented instruction
//   out_opcode   out  8  opcode byte
//   out_operand  out 16  operand, byte 1 in [7:0], byte 2 in [15:8]
//   out_length   out  2  instruction length in bytes (1..3)
//   out_illegal  out  1  reserved opcode class flag
//
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN
//   defined   : class-11 opcodes raise out_illegal for the whole hold period
//   undefined : class-11 opcodes are plain 1-byte instructions, out_illegal=0
// -----------------------------------------------------------------------------
module decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        enabled,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_opcode,
  output logic [15:0] out_operand,
  output logic [1:0]  out_length,
  output logic        out_illegal
);

  // Decoder states
  localparam logic [1:0] S_OPC  = 2'd0;  // waiting for opcode
  localparam logic [1:0] S_OP1  = 2'd1;  // waiting for operand byte 1
  localparam logic [1:0] S_OP2  = 2'd2;  // waiting for operand byte 2
  localparam logic [1:0] S_HOLD = 2'd3;  // instruction presented

  // Length classes taken from opcode[7:6]
  localparam logic [1:0] CLS_1B  = 2'b00;
  localparam logic [1:0] CLS_2B  = 2'b01;
  localparam logic [1:0] CLS_3B  = 2'b10;
  localparam logic [1:0] CLS_RSV = 2'b11;

  // Instruction length in bytes for a given opcode class; the reserved class
  // behaves as a 1-byte instruction.
  function automatic logic [1:0] len_of_class(input logic [1:0] cls);
    logic [1:0] len;
    case (cls)
      CLS_1B:  len = 2'd1;
      CLS_2B:  len = 2'd2;
      CLS_3B:  len = 2'd3;
      CLS_RSV: len = 2'd1;
      default: len = 2'd1;
    endcase
    return len;
  endfunction

  // True when an opcode of this class needs at least one operand byte.
  function automatic logic has_operand(input logic [1:0] cls);
    logic res;
    case (cls)
      CLS_2B:  res = 1'b1;
      CLS_3B:  res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [7:0]  r_opcode;
  logic [15:0] r_operand;
  logic [1:0]  r_length;
  logic        r_valid;
  logic        w_accept;
  logic        w_consume;
  logic [1:0]  w_class;

  // Bytes are only taken outside HOLD; the reset term keeps the handshake
  // closed during the reset cycle so a byte can never slip past a reset.
  assign in_ready  = enabled && !reset && (r_state != S_HOLD);
  assign w_accept  = in_valid && in_ready;
  assign w_consume = r_valid && out_ready;
  // Class of the opcode already latched; used while collecting operands.
  assign w_class   = r_opcode[7:6];

  // Next-state decode for the byte collection FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_OPC: begin
        if (w_accept) begin
          if (has_operand(in_data[7:6])) begin
            w_state_nxt = S_OP1;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end else begin
          w_state_nxt = S_OPC;
        end
      end
      S_OP1: begin
        if (w_accept) begin
          if (w_class == CLS_3B) begin
            w_state_nxt = S_OP2;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end else begin
          w_state_nxt = S_OP1;
        end
      end
      S_OP2: begin
        if (w_accept) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_OP2;
        end
      end
      S_HOLD: begin
        if (w_consume) begin
          w_state_nxt = S_OPC;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt = S_OPC;
      end
    endcase
  end

  // State register and output-valid flag; valid is high exactly in HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_OPC;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt == S_HOLD);
    end
  end

  // Instruction fields; the operand is cleared when a new opcode arrives so
  // unused operand bytes always read as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_opcode  <= 8'h00;
      r_operand <= 16'h0000;
      r_length  <= 2'd0;
    end else if (w_accept) begin
      case (r_state)
        S_OPC: begin
          r_opcode  <= in_data;
          r_operand <= 16'h0000;
          r_length  <= len_of_class(in_data[7:6]);
        end
        S_OP1: begin
          r_operand[7:0] <= in_data;
        end
        S_OP2: begin
          r_operand[15:8] <= in_data;
        end
        default: begin
          r_operand <= r_operand;
        end
      endcase
    end else begin
      r_opcode  <= r_opcode;
      r_operand <= r_operand;
      r_length  <= r_length;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic r_illegal;

  // Reserved-class flag: set with the opcode, cleared when execute takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_illegal <= 1'b0;
    end else if (w_accept && (r_state == S_OPC)) begin
      r_illegal <= (in_data[7:6] == CLS_RSV);
    end else if (w_consume) begin
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= r_illegal;
    end
  end

  assign out_illegal = r_illegal;
`else
  assign out_illegal = 1'b0;
`endif

  assign out_valid   = r_valid;
  assign out_opcode  = r_opcode;
  assign out_operand = r_operand;
  assign out_length  = r_length;

endmodule

// File: tb/tb_decode.sv
`timescale 1ns/1ps
module tb_decode;

  logic        clk;
  logic        reset;
  logic        enabled;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_opcode;
  logic [15:0] out_operand;
  logic [1:0]  out_length;
  logic        out_illegal;

  decode dut (
    .clk         (clk),
    .reset       (reset),
    .enabled     (enabled),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_operand (out_operand),
    .out_length  (out_length),
    .out_illegal (out_illegal)
  );

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [1:0]  length;
    logic        illegal;
  } instr_t;

  instr_t     expq[$];
  logic [7:0] pbytes[$];

  int total = 0;
  int bad   = 0;
  bit rnd_mode = 1'b0;
  int ready_pct = 100;
  int hold_cycles = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: group accepted bytes into instructions by opcode class.
  task automatic model_accept(input logic [7:0] b, output bit done);
    logic [7:0] op;
    int len;
    instr_t e;
    done = 1'b0;
    pbytes.push_back(b);
    op = pbytes[0];
    if (op[7:6] == 2'd1) len = 2;
    else if (op[7:6] == 2'd2) len = 3;
    else len = 1;
    if (pbytes.size() == len) begin
      e.opcode  = op;
      e.operand = 16'((len > 1 ? int'(pbytes[1]) : 0) + (len > 2 ? int'(pbytes[2]) * 256 : 0));
      e.length  = 2'(len);
      e.illegal = TRAP && (op[7:6] == 2'd3);
      expq.push_back(e);
      pbytes.delete();
      done = 1'b1;
    end
  endtask

  // Offer one byte until the stage takes it (bounded).
  task automatic send_byte(input logic [7:0] b);
    int n;
    bit acc;
    bit done;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 300) begin
      @(negedge clk);
      enabled  = rnd_mode ? ($urandom_range(0, 9) != 0) : 1'b1;
      in_valid = rnd_mode ? ($urandom_range(0, 4) != 0) : 1'b1;
      in_data  = in_valid ? b : 8'($urandom);
      #1;
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n++;
    end
    if (!acc) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      model_accept(b, done);
      if (done) begin
        @(negedge clk);
        #1;
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
      end
    end
  endtask

  task automatic reset_dut(input int n);
    @(negedge clk);
    reset = 1'b1;
    enabled = 1'b0;
    in_valid = 1'b0;
    pbytes.delete();
    expq.delete();
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_opcode", {24'd0, out_opcode}, 32'd0);
    chk("rst_operand", {16'd0, out_operand}, 32'd0);
    chk("rst_length", {30'd0, out_length}, 32'd0);
    chk("rst_illegal", {31'd0, out_illegal}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    enabled = 1'b1;
    #0.5;
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
  endtask

  // Monitor / scoreboard: compares every presented cycle against the queue head.
  initial begin : monitor
    bit consumed;
    instr_t e;
    consumed = 1'b0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        out_ready = 1'b0;
        consumed = 1'b0;
      end else begin
        if (consumed) chk("drop_after_consume", {31'd0, out_valid}, 32'd0);
        consumed = 1'b0;
        if (out_valid) begin
          chk("in_ready_in_hold", {31'd0, in_ready}, 32'd0);
          if (expq.size() == 0) begin
            chk("unexpected_output", {31'd0, out_valid}, 32'd0);
            out_ready = 1'b1;
          end else begin
            e = expq[0];
            chk("opcode", {24'd0, out_opcode}, {24'd0, e.opcode});
            chk("operand", {16'd0, out_operand}, {16'd0, e.operand});
            chk("length", {30'd0, out_length}, {30'd0, e.length});
            chk("illegal", {31'd0, out_illegal}, {31'd0, e.illegal});
            if (hold_cycles > 0) begin
              hold_cycles--;
              out_ready = 1'b0;
            end else if (int'($urandom_range(1, 100)) <= ready_pct) begin
              out_ready = 1'b1;
              void'(expq.pop_front());
              consumed = 1'b1;
            end else begin
              out_ready = 1'b0;
            end
          end
        end else begin
          out_ready = 1'b0;
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] op;
    int n;
    reset = 1'b1;
    enabled = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    reset_dut(2);

    // Directed cases
    send_byte(8'h05);
    send_byte(8'h4A); send_byte(8'h3F);
    repeat (3) @(negedge clk);
    hold_cycles = 3;
    send_byte(8'hA2); send_byte(8'h34); send_byte(8'h12);
    repeat (6) @(negedge clk);

    // Frozen stage: nothing may be taken while enabled is low.
    send_byte(8'h83);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      enabled = 1'b0;
      in_valid = 1'b1;
      in_data = 8'h99;
      #1;
      chk("frozen_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    send_byte(8'h11); send_byte(8'h22);
    repeat (3) @(negedge clk);

    // Reset mid-instruction discards the partial bytes.
    send_byte(8'hA2); send_byte(8'h34);
    reset_dut(1);
    send_byte(8'h05);
    repeat (3) @(negedge clk);
    send_byte(8'hC7);
    repeat (3) @(negedge clk);

    // Randomized stream
    rnd_mode = 1'b1;
    ready_pct = 60;
    for (int i = 0; i < 300; i++) begin
      op = 8'($urandom);
      if (i % 37 == 13) begin
        op[7:6] = 2'b10;
        send_byte(op);
        if ($urandom_range(0, 1) == 1) send_byte(8'($urandom));
        reset_dut(1);
      end else begin
        send_byte(op);
        if (op[7:6] == 2'b01 || op[7:6] == 2'b10) send_byte(8'($urandom));
        if (op[7:6] == 2'b10) send_byte(8'($urandom));
      end
    end

    ready_pct = 100;
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", expq.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
